moore_input_conditioner: RTL and testbench

//   Upstream front end of the tt_um_prampal_moore sequence detector. Takes two raw
//   pad-level inputs: a manual "step" button and a "data" switch. Synchronises
//   and debounces both. Emits one clean serial bit per step press
//   (bit_valid/bit_data), which the Moore machine consumes as its input stream.

---
 rtl/moore_input_conditioner.sv | 98 +++++++++
 tb/tb_moore_input_conditioner.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/moore_input_conditioner.sv
// Input front end for the Moore sequence detector: synchronises and debounces the
// step button and data switch, then emits one clean serial bit per step press.
module moore_input_conditioner #(
  parameter int unsigned DEB_CYCLES = 8,
  parameter int unsigned CNT_W      = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             step_raw,
  input  logic             data_raw,
  output logic             bit_valid,
  output logic             bit_data,
  output logic             step_level,
  output logic             data_level,
  output logic [CNT_W-1:0] bit_count
);

  localparam int unsigned CW   = $clog2(DEB_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(DEB_CYCLES - 1);
  localparam int unsigned STEP = 0;
  localparam int unsigned DATA = 1;

  logic [1:0]          raw;
  logic [1:0]          s1_q, s2_q;
  logic [1:0]          sv_q;
  logic [1:0]          lvl_q, lvl_d;
  logic [1:0][CW-1:0]  cnt_q, cnt_d;
  logic                stepd_q, stepd_d;
  logic                armed_q, armed_d;
  logic                valid_q, valid_d;
  logic                data_q, data_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic                rise;

  assign raw = {data_raw, step_raw};

  always_comb begin
    lvl_d = lvl_q;
    cnt_d = cnt_q;
    for (int unsigned ch = 0; ch < 2; ch++) begin
      if (!ena) begin
        cnt_d[ch] = '0;
      end else if (s2_q[ch] == lvl_q[ch]) begin
        cnt_d[ch] = '0;
      end else if (cnt_q[ch] == LAST) begin
        lvl_d[ch] = s2_q[ch];
        cnt_d[ch] = '0;
      end else begin
        cnt_d[ch] = cnt_q[ch] + 1'b1;
      end
    end

    // Strobes are only armed once step has been seen genuinely released (sync
    // pipeline refilled after reset, enable held), so reset release or an enable
    // edge with the button already down never yields a bit.
    armed_d = ena && (armed_q || (sv_q[1] && !s2_q[STEP] && !lvl_q[STEP]));

    stepd_d = lvl_q[STEP];
    rise    = ena && armed_q && lvl_q[STEP] && !stepd_q;
    valid_d = rise;
    data_d  = rise ? lvl_q[DATA] : data_q;
    count_d = rise ? count_q + 1'b1 : count_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q    <= '0;
      s2_q    <= '0;
      sv_q    <= '0;
      lvl_q   <= '0;
      cnt_q   <= '0;
      stepd_q <= 1'b0;
      armed_q <= 1'b0;
      valid_q <= 1'b0;
      data_q  <= 1'b0;
      count_q <= '0;
    end else begin
      s1_q    <= raw;
      s2_q    <= s1_q;
      sv_q    <= {sv_q[0], 1'b1};
      lvl_q   <= lvl_d;
      cnt_q   <= cnt_d;
      stepd_q <= stepd_d;
      armed_q <= armed_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      count_q <= count_d;
    end
  end

  assign bit_valid  = valid_q;
  assign bit_data   = data_q;
  assign step_level = lvl_q[STEP];
  assign data_level = lvl_q[DATA];
  assign bit_count  = count_q;

endmodule

// File: tb/tb_moore_input_conditioner.sv
// Scoreboard bench for moore_input_conditioner: directed presses push expected
// bits; a negedge monitor pops and compares on every bit_valid strobe.
module tb_moore_input_conditioner;

  localparam int DEB = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b1;
  logic       step_raw = 1'b0;
  logic       data_raw = 1'b0;
  logic       bit_valid, bit_data, step_level, data_level;
  logic [7:0] bit_count;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  logic [7:0] exp_cnt = '0;

  typedef struct {
    logic       d;
    logic [7:0] c;
    int         due;
  } exp_t;
  exp_t sb[$];

  moore_input_conditioner #(.DEB_CYCLES(DEB), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .step_raw(step_raw), .data_raw(data_raw),
    .bit_valid(bit_valid), .bit_data(bit_data), .step_level(step_level),
    .data_level(data_level), .bit_count(bit_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, required %0d (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One clean press: settle data, press step long enough to debounce, release.
  task automatic press(input logic d, input bit timed);
    exp_t e;
    data_raw = d;
    cycles(DEB + 4);
    exp_cnt  = exp_cnt + 8'd1;
    e.d   = d;
    e.c   = exp_cnt;
    e.due = timed ? cyc + DEB + 3 : -1;
    sb.push_back(e);
    step_raw = 1'b1;
    cycles(DEB + 6);
    step_raw = 1'b0;
    cycles(DEB + 6);
  endtask

  always @(negedge clk) begin
    if (rst_n && bit_valid) begin
      if (sb.size() == 0) begin
        chk("unexpected_strobe", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("bit_data", int'(bit_data), int'(e.d));
        chk("bit_count", int'(bit_count), int'(e.c));
        if (e.due >= 0) chk("strobe_latency_edge", cyc, e.due);
      end
    end
  end

  initial begin
    int chg;

    // 1: reset with both raw inputs high
    step_raw = 1'b1;
    data_raw = 1'b1;
    rst_n    = 1'b0;
    cycles(3);
    chk("rst_bit_valid", int'(bit_valid), 0);
    chk("rst_step_level", int'(step_level), 0);
    chk("rst_data_level", int'(data_level), 0);
    chk("rst_bit_count", int'(bit_count), 0);
    rst_n = 1'b1;
    cycles(DEB + 1);
    chk("t1_step_level_edge9", int'(step_level), 0);
    cycles(1);
    chk("t1_step_level_edge10", int'(step_level), 1);
    chk("t1_data_level_edge10", int'(data_level), 1);
    cycles(5);
    chk("t1_bit_count", int'(bit_count), 0);

    // 2: release, then one long press with data=1 and latency check
    step_raw = 1'b0;
    cycles(20);
    chk("t2_released", int'(step_level), 0);
    begin
      exp_t e;
      exp_cnt = exp_cnt + 8'd1;
      e.d = 1'b1; e.c = exp_cnt; e.due = cyc + DEB + 3;
      sb.push_back(e);
    end
    step_raw = 1'b1;
    cycles(30);
    step_raw = 1'b0;
    cycles(DEB + 6);
    chk("t2_bit_data_held", int'(bit_data), 1);

    // 3: step toggling every 3 cycles never debounces
    chg = 0;
    for (int i = 0; i < 40; i++) begin
      if (i % 3 == 0) step_raw = ~step_raw;
      @(negedge clk);
      if (step_level !== 1'b0) chg++;
    end
    step_raw = 1'b0;
    cycles(DEB + 6);
    chk("t3_glitch_level_changes", chg, 0);

    // 5: enable dropped mid-press, restored with step still held
    step_raw = 1'b1;
    cycles(4);
    ena = 1'b0;
    cycles(20);
    chk("t5_level_held", int'(step_level), 0);
    chk("t5_count_held", int'(bit_count), int'(exp_cnt));
    ena = 1'b1;
    cycles(20);
    chk("t5_level_after_ena", int'(step_level), 1);
    chk("t5_count_no_strobe", int'(bit_count), int'(exp_cnt));
    step_raw = 1'b0;
    cycles(DEB + 6);
    press(1'b0, 1'b1);

    // 6: async reset 4 cycles into a press
    data_raw = 1'b1;
    cycles(DEB + 4);
    step_raw = 1'b1;
    cycles(4);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_async_bit_count", int'(bit_count), 0);
    chk("t6_async_data_level", int'(data_level), 0);
    chk("t6_async_bit_data", int'(bit_data), 0);
    exp_cnt = '0;
    cycles(2);
    rst_n = 1'b1;
    cycles(20);
    chk("t6_level_after_release", int'(step_level), 1);
    chk("t6_no_strobe_count", int'(bit_count), 0);
    step_raw = 1'b0;
    cycles(DEB + 6);
    press(1'b1, 1'b1);

    // 4: count wrap over 256 presses, alternating data
    rst_n = 1'b0;
    step_raw = 1'b0;
    data_raw = 1'b0;
    exp_cnt = '0;
    cycles(2);
    rst_n = 1'b1;
    cycles(4);
    for (int i = 0; i < 255; i++) press((i % 2) == 0, 1'b0);
    chk("t4_count_255", int'(bit_count), 255);
    press(1'b0, 1'b1);
    chk("t4_count_wrapped", int'(bit_count), 0);

    cycles(4);
    chk("missing_strobes", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
